run_monitor: RTL

Parametrised run-control and watchdog block that sits beside `top`, observes the stage-1 next-PC and retire strobe, and ends or pauses a run. It generalises a single fixed "stop at PC N" check into NUM_BP programmable breakpoints with resume, a cycle-limit timeout, a stalled-PC detector, and cycle and retire counters. A `halt` output freezes the CPU, and a reason code reports why the run stopped. It is synthesizable, so the same run control works in simulation and on an FPGA build.

---
 rtl/run_mon_pkg.sv | 25 ++
 rtl/bp_match.sv | 33 +++
 rtl/run_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared types for the run_monitor block.
//   run_state_t   - run-control FSM states
//   stop_reason_t - reason code reported when a run pauses or ends
//   idx_width()   - width of a slot index, never narrower than one bit
package run_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StBreak = 2'd2,
        StDone  = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        ReasonNone    = 2'd0,
        ReasonBreak   = 2'd1,
        ReasonTimeout = 2'd2,
        ReasonStall   = 2'd3
    } stop_reason_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_match.sv
// bp_match: combinational breakpoint comparator bank.
//   pc      in  observed PC
//   bp_addr in  packed slot addresses, slot i at [i*PC_WIDTH +: PC_WIDTH]
//   bp_en   in  per-slot enable
//   hit     out some enabled slot equals pc
//   idx     out lowest matching slot index (0 when no hit)
module bp_match
    import run_mon_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 16,
    parameter int unsigned NUM_BP   = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_BP)
) (
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    output logic                       hit,
    output logic [IDX_W-1:0]           idx
);

    // Scan from the top slot down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i*PC_WIDTH +: PC_WIDTH] == pc)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run-control and watchdog beside the CPU.
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse: clear counters and enter RUN from any state
//   pc, retire    observed stage-1 next-PC and retire strobe
//   bp_addr/bp_en programmable breakpoints (lowest index wins)
//   cycle_limit   timeout threshold, 0 disables
//   resume        pulse: leave BREAK back to RUN
//   halt, done    freeze request / run terminated
//   reason        0 none, 1 break, 2 timeout, 3 stall
//   bp_hit_idx    slot that caused the last break
//   cycle_count   RUN cycles, retire_count retires during RUN (both saturate)
module run_monitor
    import run_mon_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned NUM_BP      = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned STALL_LIMIT = 16,
    localparam int unsigned IDX_W      = idx_width(NUM_BP)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic                       retire,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    input  logic [CNT_WIDTH-1:0]       cycle_limit,
    input  logic                       resume,
    output logic                       halt,
    output logic                       done,
    output logic [1:0]                 reason,
    output logic [IDX_W-1:0]           bp_hit_idx,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [CNT_WIDTH-1:0]       retire_count
);

    // One extra bit so the counter can step past STALL_LIMIT-1 without wrapping.
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    run_state_t           state_q;
    stop_reason_t         reason_q;
    logic                 halt_q;
    logic                 done_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] retire_q;
    logic [STALL_W-1:0]   stall_q;
    logic                 suppress_q;
    logic [PC_WIDTH-1:0]  sup_pc_q;
    logic [PC_WIDTH-1:0]  pc_prev_q;

    logic                 bp_hit;
    logic [IDX_W-1:0]     bp_idx;
    logic [CNT_WIDTH-1:0] cycle_d;
    logic [CNT_WIDTH-1:0] retire_d;
    logic [STALL_W-1:0]   stall_d;
    logic                 pc_same;
    logic                 timeout_evt;
    logic                 stall_evt;
    logic                 break_evt;

    bp_match #(
        .PC_WIDTH (PC_WIDTH),
        .NUM_BP   (NUM_BP)
    ) u_bp_match (
        .pc      (pc),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .hit     (bp_hit),
        .idx     (bp_idx)
    );

    always_comb begin
        cycle_d     = (&cycle_q) ? cycle_q : cycle_q + CNT_WIDTH'(1);
        retire_d    = (retire && !(&retire_q)) ? retire_q + CNT_WIDTH'(1) : retire_q;
        pc_same     = (pc == pc_prev_q);
        stall_d     = pc_same ? stall_q + STALL_W'(1) : '0;
        timeout_evt = (cycle_limit != '0) && (cycle_d == cycle_limit);
        stall_evt   = pc_same && (stall_q == STALL_W'(STALL_LIMIT - 1));
        // After a resume the PC we stopped on must not re-trigger until it moves.
        break_evt   = bp_hit && !(suppress_q && (pc == sup_pc_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            reason_q   <= ReasonNone;
            halt_q     <= 1'b1;
            done_q     <= 1'b0;
            idx_q      <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            suppress_q <= 1'b0;
            sup_pc_q   <= '0;
            pc_prev_q  <= '0;
        end else begin
            pc_prev_q <= pc;
            if (start) begin
                state_q    <= StRun;
                reason_q   <= ReasonNone;
                halt_q     <= 1'b0;
                done_q     <= 1'b0;
                idx_q      <= '0;
                cycle_q    <= '0;
                retire_q   <= '0;
                stall_q    <= '0;
                suppress_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StRun: begin
                        cycle_q  <= cycle_d;
                        retire_q <= retire_d;
                        stall_q  <= stall_d;
                        if (suppress_q && (pc != sup_pc_q)) begin
                            suppress_q <= 1'b0;
                        end
                        if (timeout_evt) begin
                            state_q  <= StDone;
                            reason_q <= ReasonTimeout;
                            halt_q   <= 1'b1;
                            done_q   <= 1'b1;
                        end else if (stall_evt) begin
                            state_q  <= StDone;
                            reason_q <= ReasonStall;
                            halt_q   <= 1'b1;
                            done_q   <= 1'b1;
                        end else if (break_evt) begin
                            state_q  <= StBreak;
                            reason_q <= ReasonBreak;
                            halt_q   <= 1'b1;
                            idx_q    <= bp_idx;
                            sup_pc_q <= pc;
                        end
                    end
                    StBreak: begin
                        if (resume) begin
                            state_q    <= StRun;
                            halt_q     <= 1'b0;
                            suppress_q <= 1'b1;
                        end
                    end
                    StDone: ;
                    default: ;
                endcase
            end
        end
    end

    assign halt         = halt_q;
    assign done         = done_q;
    assign reason       = reason_q;
    assign bp_hit_idx   = idx_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule
